// File: rtl/vga_fb_scheduler_pkg.sv
// Shared types and constants for the VGA frame-buffer scheduler.
// This covers the schedule state, the NES frame geometry and the queued write entry.
package vga_fb_scheduler_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    REPLAY = 2'd1,
    BLANK  = 2'd2
  } sched_state_t;

  localparam int NES_W = 256;
  localparam int NES_H = 240;
  localparam int PIX_W = 6;

  typedef struct packed {
    logic [7:0]       y;
    logic [7:0]       x;
    logic [PIX_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vga_line_buf.sv
// A 256x6 line buffer with one write port and one registered read port.
// It holds the source row fetched on an even VGA line so that the odd line can replay it.
module vga_line_buf
  import vga_fb_scheduler_pkg::*;
(
  input  logic             dclk,
  input  logic             we,
  input  logic [7:0]       waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [7:0]       raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [NES_W];

  // NOTE: the storage is not reset. A FETCH line rewrites every entry before the REPLAY line reads it.
  always_ff @(posedge dclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_fb_scheduler.sv
// This block arbitrates the single frame-buffer RAM port between scan-out reads and PPU writes.
// Even visible lines read the RAM and odd lines replay the line buffer; writes drain outside FETCH.
module vga_fb_scheduler
  import vga_fb_scheduler_pkg::*;
#(
  parameter int H_ACTIVE   = 256,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             dclk,
  input  logic             Reset,
  input  logic [10:0]      DrawX,
  input  logic [10:0]      DrawY,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_x,
  input  logic [7:0]       wr_y,
  input  logic [PIX_W-1:0] wr_data,
  output logic [15:0]      mem_addr,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  sched_state_t state, state_q;
  logic         visible;
  logic [7:0]   src_x, src_y;

  // The state is decoded combinationally from the raster position, with no extra latency.
  always_comb begin
    visible = (DrawX < 11'(H_ACTIVE)) && (DrawY < 11'(V_ACTIVE));
    src_x   = DrawX[7:0];
    src_y   = DrawY[8:1];
    state   = BLANK;
    if (visible) state = DrawY[0] ? REPLAY : FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments. Every register therefore sees values from before the edge.
  always_ff @(posedge dclk) begin
    if (Reset) state_q <= BLANK;
    else       state_q <= state;
  end

  // Write FIFO
  wr_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  wr_entry_t        head;
  logic             full, empty, push, pop;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = Reset | ~full;
  assign push     = wr_valid & ~full & ~Reset;
  assign pop      = ~Reset & ~empty & (state != FETCH);
  assign head     = fifo_mem[rd_ptr];

  always_ff @(posedge dclk) begin
    if (push) fifo_mem[wr_ptr] <= '{y: wr_y, x: wr_x, data: wr_data};
  end

  always_ff @(posedge dclk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The RAM port carries one command per cycle. FETCH reads have priority, because pops are blocked during FETCH.
  // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!Reset) begin
      if (state == FETCH) begin
        mem_addr = {src_y, src_x};
      end else if (pop && (head.y < 8'(NES_H))) begin
        mem_we    = 1'b1;
        mem_addr  = {head.y, head.x};
        mem_wdata = head.data;
      end
    end
  end

  // Scan-out pipeline: stage 1 has the RAM or line-buffer data, and stage 2 registers the pixel.
  logic [7:0]       x_q;
  logic [PIX_W-1:0] lb_rdata;

  always_ff @(posedge dclk) begin
    x_q <= src_x;
  end

  vga_line_buf u_line_buf (
    .dclk  (dclk),
    .we    (state_q == FETCH),
    .waddr (x_q),
    .wdata (mem_rdata),
    .raddr (src_x),
    .rdata (lb_rdata)
  );

  always_ff @(posedge dclk) begin
    if (Reset) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      pix_valid <= (state_q != BLANK);
      case (state_q)
        FETCH:   pix_data <= mem_rdata;
        REPLAY:  pix_data <= lb_rdata;
        default: pix_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler, with a behavioural single-port RAM that has 1-cycle read latency.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_vga_fb_scheduler;
  logic        dclk = 1'b0;
  logic        Reset;
  logic [10:0] DrawX, DrawY;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x, wr_y;
  logic [5:0]  wr_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [5:0]  mem_wdata;
  logic [5:0]  mem_rdata;
  logic [5:0]  pix_data;
  logic        pix_valid;

  int n_checks = 0;
  int n_pass   = 0;

  logic [5:0] ram [65536];

  always #5 dclk = ~dclk;

  always @(posedge dclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  vga_fb_scheduler #(.H_ACTIVE(256), .V_ACTIVE(480), .FIFO_DEPTH(4)) dut (
    .dclk      (dclk),
    .Reset     (Reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
  );

  task automatic cyc(input int x, input int y);
    @(negedge dclk);
    DrawX = 11'(x); DrawY = 11'(y);
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    #1;
  endtask

  task automatic cyc_wr(input int x, input int y, input logic [7:0] wx, input logic [7:0] wy, input logic [5:0] wd);
    @(negedge dclk);
    DrawX = 11'(x); DrawY = 11'(y);
    wr_valid = 1'b1; wr_x = wx; wr_y = wy; wr_data = wd;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    cyc(0, 0);
    n_checks++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", wr_ready); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0) $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== 6'h0) $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); else n_pass++;
    cyc(1, 0);
    cyc(2, 0);
    n_checks++; if ({pix_valid, pix_data} !== 7'h0) $display("FAIL reset_pix: got valid=%b data=%h want 0/00", pix_valid, pix_data); else n_pass++;
    cyc(3, 0);
    Reset = 1'b0; #1;
    n_checks++; if (mem_addr !== 16'h0003) $display("FAIL post_reset_decode: got addr=%h want 0003", mem_addr); else n_pass++;
    cyc(4, 0);
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL post_reset_pix_valid0: got %b want 0", pix_valid); else n_pass++;
    cyc(5, 0);
    n_checks++; if (pix_valid !== 1'b1) $display("FAIL post_reset_pix_valid1: got %b want 1", pix_valid); else n_pass++;
  endtask

  task automatic test_line_double();
    logic [7:0] xb;
    logic [7:0] pb;
    int p;
    for (int i = 0; i < 256; i++) begin
      xb = 8'(i);
      ram[16'h0500 + 16'(i)] = xb[5:0];
    end
    for (int y = 10; y <= 11; y++) begin
      for (int x = 0; x < 260; x++) begin
        cyc(x, y);
        xb = 8'(x);
        if (x < 256) begin
          n_checks++;
          if (y == 10) begin
            if ({mem_we, mem_addr} !== {1'b0, 8'h05, xb})
              $display("FAIL fetch_addr y=%0d x=%0d: got we=%b addr=%h want 0/05%h", y, x, mem_we, mem_addr, xb);
            else n_pass++;
          end else begin
            if ({mem_we, mem_addr} !== 17'h0)
              $display("FAIL replay_no_ram y=%0d x=%0d: got we=%b addr=%h want 0/0000", y, x, mem_we, mem_addr);
            else n_pass++;
          end
        end
        if (x >= 2) begin
          p = x - 2;
          pb = 8'(p);
          n_checks++;
          if (p < 256) begin
            if ({pix_valid, pix_data} !== {1'b1, pb[5:0]})
              $display("FAIL pix y=%0d x=%0d: got valid=%b data=%h want 1/%h", y, p, pix_valid, pix_data, pb[5:0]);
            else n_pass++;
          end else begin
            if ({pix_valid, pix_data} !== 7'h0)
              $display("FAIL pix_blank y=%0d x=%0d: got valid=%b data=%h want 0/00", y, p, pix_valid, pix_data);
            else n_pass++;
          end
        end
      end
    end
  endtask

  task automatic test_fifo_fill();
    logic [7:0] ex [5];
    logic [7:0] ey [5];
    logic [5:0] ed [5];
    int accepted = 0;
    int fetch_writes = 0;
    for (int i = 0; i < 5; i++) begin
      ex[i] = 8'(8'h20 + i);
      ey[i] = 8'(8'h10 + i);
      ed[i] = 6'(6'h30 + i);
    end
    for (int x = 10; x < 256; x++) begin
      cyc_wr(x, 0, ex[accepted], ey[accepted], ed[accepted]);
      if (x == 14) begin
        n_checks++; if (wr_ready !== 1'b0) $display("FAIL fill_wr_ready_low: got %b want 0", wr_ready); else n_pass++;
      end
      if (mem_we !== 1'b0) fetch_writes++;
      if (wr_ready === 1'b1 && accepted < 4) accepted++;
    end
    n_checks++; if (accepted != 4) $display("FAIL fill_accepted: got %0d want 4", accepted); else n_pass++;
    n_checks++; if (fetch_writes != 0) $display("FAIL fill_no_write_in_fetch: got %0d writes want 0", fetch_writes); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc(256 + i, 0);
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, ey[i], ex[i], ed[i]})
        $display("FAIL drain_%0d: got we=%b addr=%h data=%h want 1/%h%h/%h", i, mem_we, mem_addr, mem_wdata, ey[i], ex[i], ed[i]);
      else n_pass++;
    end
    cyc(260, 0);
    n_checks++; if ({mem_we, wr_ready} !== 2'b01) $display("FAIL drain_done: got we=%b ready=%b want 0/1", mem_we, wr_ready); else n_pass++;
  endtask

  task automatic test_replay_write();
    cyc_wr(20, 1, 8'h12, 8'h34, 6'h2A);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL replay_push_cycle: got we=%b want 0", mem_we); else n_pass++;
    cyc(21, 1);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h3412, 6'h2A})
      $display("FAIL replay_write: got we=%b addr=%h data=%h want 1/3412/2a", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    cyc(22, 1);
    n_checks++; if ({mem_we, mem_addr} !== 17'h0) $display("FAIL replay_idle: got we=%b addr=%h want 0/0000", mem_we, mem_addr); else n_pass++;
    n_checks++; if (ram[16'h3412] !== 6'h2A) $display("FAIL replay_ram: got %h want 2a", ram[16'h3412]); else n_pass++;
  endtask

  task automatic test_discard();
    cyc_wr(0, 481, 8'h05, 8'd240, 6'h07);
    cyc_wr(1, 481, 8'h60, 8'h50, 6'h11);
    n_checks++; if ({mem_we, mem_addr} !== 17'h0) $display("FAIL discard_pop: got we=%b addr=%h want 0/0000", mem_we, mem_addr); else n_pass++;
    cyc(2, 481);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h5060, 6'h11})
      $display("FAIL discard_next: got we=%b addr=%h data=%h want 1/5060/11", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    cyc(3, 481);
    n_checks++; if (ram[16'hF005] !== 6'h00) $display("FAIL discard_ram: got %h want 00", ram[16'hF005]); else n_pass++;
    n_checks++; if ({mem_we, wr_ready} !== 2'b01) $display("FAIL discard_empty: got we=%b ready=%b want 0/1", mem_we, wr_ready); else n_pass++;
  endtask

  task automatic test_boundary();
    logic [7:0] xb;
    cyc_wr(250, 2, 8'h41, 8'h40, 6'h15);
    for (int x = 251; x < 256; x++) begin
      cyc(x, 2);
      xb = 8'(x);
      n_checks++;
      if ({mem_we, mem_addr} !== {1'b0, 8'h01, xb})
        $display("FAIL edge_read x=%0d: got we=%b addr=%h want 0/01%h", x, mem_we, mem_addr, xb);
      else n_pass++;
    end
    cyc(256, 2);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h4041, 6'h15})
      $display("FAIL edge_write: got we=%b addr=%h data=%h want 1/4041/15", mem_we, mem_addr, mem_wdata);
    else n_pass++;
    cyc(257, 2);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL edge_after: got we=%b want 0", mem_we); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int late_writes = 0;
    for (int i = 0; i < 3; i++) cyc_wr(30 + i, 4, 8'(8'h80 + i), 8'(8'h70 + i), 6'(i + 1));
    cyc(33, 4);
    Reset = 1'b1; #1;
    n_checks++;
    if ({wr_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0})
      $display("FAIL mid_reset_hold: got ready=%b we=%b addr=%h want 1/0/0000", wr_ready, mem_we, mem_addr);
    else n_pass++;
    cyc(34, 481);
    Reset = 1'b0; #1;
    n_checks++;
    if ({wr_ready, mem_we, pix_valid} !== 3'b100)
      $display("FAIL mid_reset_after: got ready=%b we=%b pix_valid=%b want 1/0/0", wr_ready, mem_we, pix_valid);
    else n_pass++;
    for (int x = 35; x < 40; x++) begin
      cyc(x, 481);
      if (mem_we !== 1'b0) late_writes++;
    end
    n_checks++; if (late_writes != 0) $display("FAIL mid_reset_flushed: got %0d writes want 0", late_writes); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ram[16'h7080 + 16'(i * 257)] !== 6'h00)
        $display("FAIL mid_reset_ram_%0d: got %h want 00", i, ram[16'h7080 + 16'(i * 257)]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 6'h0;
    Reset = 1'b1;
    DrawX = '0; DrawY = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    test_reset();
    test_line_double();
    test_fifo_fill();
    test_replay_write();
    test_discard();
    test_boundary();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
